// File: rtl/led_segment_capture.sv
// Recovers four hex nibbles from a multiplexed seven-segment bus by waiting for each digit slot to settle.
// Define SEG_ACTIVE_LOW_EN for common-anode boards, where the segment pins are active-low.
module led_segment_capture #(
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] ds_en,
  input  logic [6:0] ds_reg,
  output logic [3:0] num1,
  output logic [3:0] num2,
  output logic [3:0] num3,
  output logic [3:0] num4,
  output logic [3:0] digit_valid,
  output logic       frame_done,
  output logic       bad_code
);

  typedef enum logic {ST_WAIT, ST_HELD} run_state_t;

  localparam logic [CNT_W-1:0] CAP_CNT = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SAT_CNT = CNT_W'(STABLE_CYCLES);

  logic [6:0]       seg_in;
  logic [3:0]       s_en;
  logic [6:0]       s_seg;
  logic [CNT_W-1:0] cnt;
  run_state_t       state, state_n;
  logic             changed, capture;

  logic [3:0] num_q [4];
  logic [3:0] num_n [4];
  logic [3:0] valid_n, seen, seen_n;
  logic       done_n, bad_n;
  logic       en_onehot;
  logic [1:0] en_idx;
  logic [4:0] glyph;

`ifdef SEG_ACTIVE_LOW_EN
  assign seg_in = ~ds_reg;
`else
  assign seg_in = ds_reg;
`endif

  // Returns {hit, value}; blank and unknown patterns both miss here.
  function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
    case (seg)
      7'b0111111: return {1'b1, 4'h0};
      7'b0000110: return {1'b1, 4'h1};
      7'b1011011: return {1'b1, 4'h2};
      7'b1001111: return {1'b1, 4'h3};
      7'b1100110: return {1'b1, 4'h4};
      7'b1101101: return {1'b1, 4'h5};
      7'b1111101: return {1'b1, 4'h6};
      7'b0000111: return {1'b1, 4'h7};
      7'b1111111: return {1'b1, 4'h8};
      7'b1101111: return {1'b1, 4'h9};
      7'b1110111: return {1'b1, 4'hA};
      7'b1111100: return {1'b1, 4'hB};
      7'b1011000: return {1'b1, 4'hC};
      7'b1011110: return {1'b1, 4'hD};
      7'b1111001: return {1'b1, 4'hE};
      7'b1110001: return {1'b1, 4'hF};
      default:    return 5'b0;
    endcase
  endfunction

  assign changed = ({ds_en, seg_in} != {s_en, s_seg});

  always_ff @(posedge clk) begin
    if (rst) begin
      s_en  <= 4'b1111;
      s_seg <= 7'b0;
      cnt   <= '0;
      state <= ST_WAIT;
    end else begin
      s_en  <= ds_en;
      s_seg <= seg_in;
      state <= state_n;
      if (changed)
        cnt <= CNT_W'(1);
      else if (cnt != SAT_CNT)
        cnt <= cnt + CNT_W'(1);
    end
  end

  // A run captures exactly once, on the edge that leaves WAIT.
  always_comb begin
    state_n = state;
    capture = 1'b0;
    if (changed) begin
      state_n = ST_WAIT;
    end else if (state == ST_WAIT && cnt == CAP_CNT) begin
      state_n = ST_HELD;
      capture = 1'b1;
    end
  end

  always_comb begin
    en_onehot = 1'b1;
    en_idx    = 2'd0;
    case (s_en)
      4'b1110: en_idx = 2'd0;
      4'b1101: en_idx = 2'd1;
      4'b1011: en_idx = 2'd2;
      4'b0111: en_idx = 2'd3;
      default: en_onehot = 1'b0;
    endcase
  end

  assign glyph = decode_glyph(s_seg);

  always_comb begin
    num_n   = num_q;
    valid_n = digit_valid;
    seen_n  = seen;
    done_n  = 1'b0;
    bad_n   = 1'b0;
    if (capture && s_en != 4'b1111) begin
      if (!en_onehot) begin
        bad_n = 1'b1;
      end else if (glyph[4]) begin
        num_n[en_idx]   = glyph[3:0];
        valid_n[en_idx] = 1'b1;
        seen_n[en_idx]  = 1'b1;
      end else if (s_seg == 7'b0) begin
        valid_n[en_idx] = 1'b0;
        seen_n[en_idx]  = 1'b1;
      end else begin
        bad_n = 1'b1;
      end
      // The capture that completes the set both reports and restarts the frame.
      if (seen_n == 4'b1111) begin
        done_n = 1'b1;
        seen_n = 4'b0000;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) num_q[i] <= 4'h0;
      digit_valid <= 4'b0000;
      seen        <= 4'b0000;
      frame_done  <= 1'b0;
      bad_code    <= 1'b0;
    end else begin
      num_q       <= num_n;
      digit_valid <= valid_n;
      seen        <= seen_n;
      frame_done  <= done_n;
      bad_code    <= bad_n;
    end
  end

  assign num1 = num_q[0];
  assign num2 = num_q[1];
  assign num3 = num_q[2];
  assign num4 = num_q[3];

endmodule
